pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the five-stage pipeline.
- Resolves branches and jumps from the MEM-stage outputs of the EX/MEM register and redirects the PC.
- Generates the synchronous flush and stall strobes for the IF/ID, ID/EX and EX/MEM registers, including load-use bubbles.
- Freezes the machine when the finish marker retires in WB.

Parameters:
- AWIDTH, 32, width of PC and branch/jump target addresses.
- CWIDTH, 32, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_bbne, mem_bbeq, mem_bblez, mem_bbgtz, mem_jump  in  1 each  MEM-stage branch/jump control bits.
- mem_zero, mem_negative  in  1 each  MEM-stage ALU flags.
- mem_branaddr  in  AWIDTH  branch target.
- mem_jmpaddr  in  AWIDTH  jump target.
- idex_memrd  in  1  EX-stage instruction is a load.
- idex_rt  in  5  load destination register.
- ifid_rs, ifid_rt  in  5 each  ID-stage source registers.
- ifid_uses_rt  in  1  ID-stage instruction reads rt.
- wb_fin  in  1  finish marker in WB.
- pc_redirect  out  1  PC loads pc_target.
- pc_target  out  AWIDTH  redirect address.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID.
- flush_ifid, flush_idex, flush_exmem  out  1 each  synchronous flush strobes.
- halted  out  1  machine frozen.
- perf_flush_cnt, perf_stall_cnt  out  CWIDTH each  present only with PIPECTRL_PERF_EN.

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately forces state=RUN and halted=0. While rst_n=0, all strobe outputs are 0 and pc_target=0.
- taken = mem_jump | (mem_bbeq & mem_zero) | (mem_bbne & ~mem_zero) | (mem_bblez & (mem_zero | mem_negative)) | (mem_bbgtz & ~mem_zero & ~mem_negative).
- pc_target = mem_jmpaddr if mem_jump, else mem_branaddr. Jump wins if several control bits are set.
- Load-use hazard: luh = idex_memrd & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt))).
- FSM states are RUN, SQUASH and HALT.
- RUN, when taken:
  - Same cycle (combinational), assert pc_redirect=1 and flush_ifid=flush_idex=flush_exmem=1. stall_pc=stall_ifid=0.
  - Next state is SQUASH.
- RUN, when not taken and luh=1:
  - Assert stall_pc=1, stall_ifid=1 and flush_idex=1 (one bubble). pc_redirect=0.
  - State stays RUN.
  - The stall repeats each cycle luh remains true.
- RUN, otherwise: all strobes are 0.
- SQUASH:
  - Lasts exactly one cycle. Branch inputs and luh are ignored, and all strobes are 0.
  - Next state is RUN.
  - This protects against stale flags while the EX/MEM flush settles.
- Priority, highest first: wb_fin, then taken, then luh.
- wb_fin=1 in RUN or SQUASH: next state is HALT.
  - That same cycle, assert flush_ifid, flush_idex and flush_exmem, plus stall_pc. Assert no pc_redirect, even if taken.
- HALT:
  - halted=1 (registered, so it rises the cycle after wb_fin). stall_pc=1 and stall_ifid=1; flushes are 0.
  - All inputs are ignored. Only rst_n exits HALT.
- Reset asserted mid-redirect or mid-stall: state returns to RUN immediately, and no strobes are asserted thereafter until inputs demand them.
- All outputs except halted and the counters are combinational from the current state and inputs. The datapath registers consume the strobes at the next rising clk edge.

Optional Feature:
- Macro: PIPECTRL_PERF_EN.
- When defined:
  - perf_flush_cnt increments by 1 on each cycle with taken redirect.
  - perf_stall_cnt increments by 1 on each load-use stall cycle.
  - Both counters saturate at all-ones and clear to 0 on rst_n=0.
- When undefined: the ports and counters are absent, with no other behavioural change.

Test Plan:
- Branch taken: mem_bbeq=1, mem_zero=1, mem_branaddr=0x40 -> same cycle pc_redirect=1, pc_target=0x40, all three flushes=1. Next cycle (SQUASH) all strobes=0, even with mem_bbeq held at 1.
- Jump beats branch: mem_jump=1, mem_bbne=1, mem_zero=0, mem_jmpaddr=0x100, mem_branaddr=0x80 -> pc_target=0x100, pc_redirect=1.
- Load-use: idex_memrd=1, idex_rt=5, ifid_rs=5 for 1 cycle -> stall_pc=stall_ifid=flush_idex=1 for exactly 1 cycle. With idex_rt=0 -> no stall. With ifid_rt=5 and ifid_uses_rt=0 -> no stall.
- Branch with simultaneous luh: taken=1 and luh=1 -> redirect plus three flushes, stall_pc=0.
- Finish: wb_fin=1 while mem_jump=1 -> no redirect, flushes=1. halted=1 the next cycle and stays 1 for 10+ cycles regardless of inputs. Asynchronous rst_n pulse mid-cycle -> halted=0 immediately.
- PIPECTRL_PERF_EN: 3 redirects and 2 stall cycles -> perf_flush_cnt=3, perf_stall_cnt=2. With CWIDTH=2 and 5 redirects -> perf_flush_cnt holds 3.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- sequencing controller for the five-stage pipeline.
//
// Resolves branches/jumps from the EX/MEM register outputs (MEM stage),
// redirects the PC, and generates the flush/stall strobes for IF/ID, ID/EX
// and EX/MEM, including load-use bubbles. Freezes the machine once the
// finish marker retires in WB; only rst_n leaves the frozen state.
//
// Parameters:
//   AWIDTH  width of PC and branch/jump targets
//   CWIDTH  width of the performance counters
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mem_bb*/mem_jump                MEM-stage branch/jump control bits
//   mem_zero, mem_negative          MEM-stage ALU flags
//   mem_branaddr, mem_jmpaddr       branch / jump targets
//   idex_memrd, idex_rt             EX-stage load and its destination
//   ifid_rs, ifid_rt, ifid_uses_rt  ID-stage source registers
//   wb_fin                          finish marker in WB
//   pc_redirect, pc_target          PC load strobe and address
//   stall_pc, stall_ifid            hold strobes
//   flush_ifid/idex/exmem           synchronous flush strobes
//   halted                          machine frozen (registered)
//   perf_flush_cnt, perf_stall_cnt  saturating event counters
//
// Optional feature macro: PIPECTRL_PERF_EN adds the two perf counters.
// Every output except halted and the counters is combinational from the
// current state and inputs, and is forced to 0 while rst_n is low.

module pipe_hazard_ctrl #(
  parameter int AWIDTH = 32,
  parameter int CWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_bbne,
  input  logic              mem_bbeq,
  input  logic              mem_bblez,
  input  logic              mem_bbgtz,
  input  logic              mem_jump,
  input  logic              mem_zero,
  input  logic              mem_negative,
  input  logic [AWIDTH-1:0] mem_branaddr,
  input  logic [AWIDTH-1:0] mem_jmpaddr,
  input  logic              idex_memrd,
  input  logic [4:0]        idex_rt,
  input  logic [4:0]        ifid_rs,
  input  logic [4:0]        ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic              wb_fin,
  output logic              pc_redirect,
  output logic [AWIDTH-1:0] pc_target,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic              halted
`ifdef PIPECTRL_PERF_EN
  ,
  output logic [CWIDTH-1:0] perf_flush_cnt,
  output logic [CWIDTH-1:0] perf_stall_cnt
`endif
);

  if (CWIDTH < 1) begin : g_cwidth_chk
    $error("CWIDTH must be at least 1");
  end

  typedef enum logic [1:0] {S_RUN, S_SQUASH, S_HALT} state_t;

  state_t r_state;
  logic   r_halted;
  logic   w_taken;
  logic   w_luh;

  assign w_taken = mem_jump
                 | (mem_bbeq  &  mem_zero)
                 | (mem_bbne  & ~mem_zero)
                 | (mem_bblez & (mem_zero | mem_negative))
                 | (mem_bbgtz & ~mem_zero & ~mem_negative);

  // r0 is never a real dependency, so a load into it cannot create a hazard.
  assign w_luh = idex_memrd & (idex_rt != 5'd0) &
                 ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (wb_fin) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (w_taken) begin
            r_state  <= S_SQUASH;
          end
        end
        S_SQUASH: begin
          // One dead cycle: the MEM flags are stale while EX/MEM flushes.
          if (wb_fin) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state  <= S_RUN;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign halted = r_halted;

  always_comb begin
    pc_redirect = 1'b0;
    pc_target   = '0;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (rst_n) begin
      pc_target = mem_jump ? mem_jmpaddr : mem_branaddr;
      case (r_state)
        S_HALT: begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
        end
        S_RUN, S_SQUASH: begin
          if (wb_fin) begin
            // Drain everything younger than the finish marker; never redirect.
            stall_pc    = 1'b1;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
          end else if (r_state == S_RUN) begin
            if (w_taken) begin
              pc_redirect = 1'b1;
              flush_ifid  = 1'b1;
              flush_idex  = 1'b1;
              flush_exmem = 1'b1;
            end else if (w_luh) begin
              stall_pc   = 1'b1;
              stall_ifid = 1'b1;
              flush_idex = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIPECTRL_PERF_EN
  logic w_stall_evt;
  assign w_stall_evt = stall_ifid & flush_idex;  // unique to a load-use bubble

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pc_redirect && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if (w_stall_evt && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl. A stimulus process
// drives inputs just after each rising edge and pushes the expected
// outputs from a behavioural model; a monitor pops and compares at the
// falling edge.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_bbne, mem_bbeq, mem_bblez, mem_bbgtz, mem_jump;
  logic          mem_zero, mem_negative;
  logic [AW-1:0] mem_branaddr, mem_jmpaddr;
  logic          idex_memrd;
  logic [4:0]    idex_rt, ifid_rs, ifid_rt;
  logic          ifid_uses_rt, wb_fin;
  logic          pc_redirect, stall_pc, stall_ifid;
  logic          flush_ifid, flush_idex, flush_exmem, halted;
  logic [AW-1:0] pc_target;
  logic [CW-1:0] perf_flush_cnt, perf_stall_cnt;

`ifndef PIPECTRL_PERF_EN
  assign perf_flush_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

  pipe_hazard_ctrl #(.AWIDTH(AW), .CWIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_bbne(mem_bbne), .mem_bbeq(mem_bbeq), .mem_bblez(mem_bblez),
    .mem_bbgtz(mem_bbgtz), .mem_jump(mem_jump),
    .mem_zero(mem_zero), .mem_negative(mem_negative),
    .mem_branaddr(mem_branaddr), .mem_jmpaddr(mem_jmpaddr),
    .idex_memrd(idex_memrd), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .wb_fin(wb_fin),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .halted(halted)
`ifdef PIPECTRL_PERF_EN
    , .perf_flush_cnt(perf_flush_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          red;
    logic [AW-1:0] tgt;
    logic          spc, sif, fi, fd, fe, hlt;
    int            fc, sc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: 0 = running, 1 = dead cycle after a redirect, 2 = frozen.
  int   mstate = 0;
  int   mfc = 0, msc = 0;
  int   halt_cycles = 0;
  localparam int CMAX = (1 << CW) - 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
    end
  endtask

  // Compute this cycle's expected outputs, queue them, advance one clock.
  task automatic step();
    exp_t e;
    bit   taken, luh;
    int   nxt;
    taken = mem_jump | (mem_bbeq & mem_zero) | (mem_bbne & !mem_zero) |
            (mem_bblez & (mem_zero | mem_negative)) |
            (mem_bbgtz & !mem_zero & !mem_negative);
    luh = idex_memrd && idex_rt != 0 &&
          (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
    e = '{red:0, tgt:(mem_jump ? mem_jmpaddr : mem_branaddr), spc:0, sif:0,
          fi:0, fd:0, fe:0, hlt:(mstate == 2), fc:mfc, sc:msc};
    nxt = mstate;
    if (mstate == 2) begin
      e.spc = 1; e.sif = 1;
    end else if (wb_fin) begin
      e.spc = 1; e.fi = 1; e.fd = 1; e.fe = 1; nxt = 2;
    end else if (mstate == 1) begin
      nxt = 0;
    end else if (taken) begin
      e.red = 1; e.fi = 1; e.fd = 1; e.fe = 1; nxt = 1;
      if (mfc < CMAX) mfc++;
    end else if (luh) begin
      e.spc = 1; e.sif = 1; e.fd = 1;
      if (msc < CMAX) msc++;
    end
    q.push_back(e);
    @(posedge clk); #1;
    mstate = nxt;
    halt_cycles = (mstate == 2) ? halt_cycles + 1 : 0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_redirect", pc_redirect, e.red);
      chk("pc_target", pc_target, e.tgt);
      chk("stall_pc", stall_pc, e.spc);
      chk("stall_ifid", stall_ifid, e.sif);
      chk("flush_ifid", flush_ifid, e.fi);
      chk("flush_idex", flush_idex, e.fd);
      chk("flush_exmem", flush_exmem, e.fe);
      chk("halted", halted, e.hlt);
`ifdef PIPECTRL_PERF_EN
      chk("perf_flush_cnt", perf_flush_cnt, e.fc[CW-1:0]);
      chk("perf_stall_cnt", perf_stall_cnt, e.sc[CW-1:0]);
`endif
    end
  end

  task automatic idle();
    {mem_bbne, mem_bbeq, mem_bblez, mem_bbgtz, mem_jump} = '0;
    {mem_zero, mem_negative, idex_memrd, ifid_uses_rt, wb_fin} = '0;
    mem_branaddr = '0; mem_jmpaddr = '0;
    idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
  endtask

  task automatic rand_in();
    mem_bbne  = ($urandom_range(3) == 0);
    mem_bbeq  = ($urandom_range(3) == 0);
    mem_bblez = ($urandom_range(3) == 0);
    mem_bbgtz = ($urandom_range(3) == 0);
    mem_jump  = ($urandom_range(5) == 0);
    mem_zero = $urandom_range(1); mem_negative = $urandom_range(1);
    mem_branaddr = $urandom; mem_jmpaddr = $urandom;
    idex_memrd = $urandom_range(1);
    idex_rt = 5'($urandom_range(3)); ifid_rs = 5'($urandom_range(3));
    ifid_rt = 5'($urandom_range(3)); ifid_uses_rt = $urandom_range(1);
    wb_fin = ($urandom_range(63) == 0);
  endtask

  // Asynchronous reset pulse away from any clock edge; called right after step().
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_halted", halted, 1'b0);
    chk("rst_stall_pc", stall_pc, 1'b0);
    chk("rst_redirect", pc_redirect, 1'b0);
    chk("rst_target", pc_target, '0);
    mstate = 0; mfc = 0; msc = 0; halt_cycles = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    mem_jump = 1'b1; mem_jmpaddr = 32'h55; wb_fin = 1'b1;
    #3;
    chk("init_redirect", pc_redirect, 1'b0);
    chk("init_target", pc_target, '0);
    chk("init_flush_exmem", flush_exmem, 1'b0);
    chk("init_stall_pc", stall_pc, 1'b0);
    chk("init_halted", halted, 1'b0);
    idle();
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // branch taken, then SQUASH with the branch still presented
    mem_bbeq = 1; mem_zero = 1; mem_branaddr = 32'h40; step();
    step();
    idle(); step();
    // jump beats a taken bne
    mem_jump = 1; mem_bbne = 1; mem_jmpaddr = 32'h100; mem_branaddr = 32'h80; step();
    idle(); step();
    // load-use, then the two non-hazard corners
    idex_memrd = 1; idex_rt = 5; ifid_rs = 5; step();
    idle(); step();
    idex_memrd = 1; idex_rt = 0; ifid_rs = 0; step();
    idex_rt = 5; ifid_rs = 1; ifid_rt = 5; ifid_uses_rt = 0; step();
    ifid_uses_rt = 1; step();
    // taken together with load-use
    mem_bbgtz = 1; mem_branaddr = 32'h200; step();
    idle(); step();
    // finish while a jump is presented, then random inputs while frozen
    mem_jump = 1; mem_jmpaddr = 32'h300; wb_fin = 1; step();
    for (int i = 0; i < 12; i++) begin rand_in(); step(); end
    async_reset();

    for (int i = 0; i < 3000; i++) begin
      if (mstate == 2 && halt_cycles >= 12) begin
        idle();
        async_reset();
      end
      rand_in();
      step();
    end
    idle();

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
